pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Sequencing controller for the decode stage of the 5-stage ARMv8 pipeline (IF/ID/EX/MEM/WB). Detects load-use hazards between the instruction in ID and a load in EX, and inserts bubbles. Flushes younger stages when a branch resolves taken in MEM. Freezes the whole pipeline while data memory is not ready. Drives the PC and pipeline-register write enables, bubble controls and flush controls.

Parameters:
LOAD_STALL_CYCLES, 1, number of bubbles inserted per load-use hazard (1..7)
FLUSH_CYCLES, 1, cycles flush outputs stay asserted after a taken branch (1..3)
CNT_W, 16, width of statistics counters (used only with HAZARD_STATS_EN)

Ports:
clk  in  1  pipeline clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
id_rn  in  5  Rn field of the instruction in ID (instr[9:5])
id_rm  in  5  second read register of the instruction in ID (post reg2_loc select)
id_uses_rn  in  1  instruction in ID reads Rn
id_uses_rm  in  1  instruction in ID reads the second register
ex_mem_read  in  1  instruction in EX is a load
ex_rd  in  5  destination register of the instruction in EX
mem_branch_taken  in  1  branch in MEM resolved taken (branch&zero | uncondbranch)
mem_ready  in  1  data memory handshake; 0 = access not complete
pc_write  out  1  PC register write enable
ifid_write  out  1  IF/ID register write enable
idex_bubble  out  1  load zeros into ID/EX control fields
hold_all  out  1  freeze ID/EX, EX/MEM, MEM/WB registers
flush_ifid  out  1  clear IF/ID
flush_idex  out  1  clear ID/EX
flush_exmem  out  1  clear EX/MEM
state  out  2  current FSM state (debug)

Behaviour:
- States: RUN=0, LSTALL=1, FLUSH=2, MWAIT=3. Reset -> RUN; stall counter = 0; flush counter = 0.
- Reset values of outputs (registered state, combinational outputs evaluated in RUN with no events): pc_write=1, ifid_write=1, idex_bubble=0, hold_all=0, all flush_*=0, state=0.
- hazard = ex_mem_read & (ex_rd != 31) & ((id_uses_rn & id_rn==ex_rd) | (id_uses_rm & id_rm==ex_rd)). X31/XZR never creates a hazard.
- Outputs are combinational from state plus current inputs, so the response is effective in the same cycle the condition appears.
- Same-cycle priority: reset > mem_ready=0 > mem_branch_taken > hazard.
- mem_ready=0, in any state:
  - Outputs: pc_write=0, ifid_write=0, hold_all=1, idex_bubble=0, flush_*=0.
  - Next state MWAIT. Saved state and counters are held, not decremented.
  - mem_branch_taken is ignored while mem_ready=0.
- MWAIT with mem_ready=1: the cycle is treated as RUN, using the held counters. If stall or flush counters are nonzero, resume LSTALL or FLUSH respectively.
- RUN with mem_branch_taken=1:
  - Outputs: flush_ifid=1, flush_idex=1, flush_exmem=1, pc_write=1 (branch target loads).
  - Flush counter := FLUSH_CYCLES-1. Next state FLUSH if the counter is nonzero, else RUN.
  - A coincident hazard is discarded; any pending stall count is cleared.
- RUN with hazard=1 (no branch):
  - Outputs: pc_write=0, ifid_write=0, idex_bubble=1.
  - Stall counter := LOAD_STALL_CYCLES-1. Next state LSTALL if the counter is nonzero, else RUN.
- LSTALL:
  - Outputs same as a hazard cycle. Counter decrements each cycle; exit to RUN on the cycle the counter reaches 0.
  - A taken branch in LSTALL preempts it: flush as in RUN, stall counter cleared.
- FLUSH:
  - flush_ifid=1, flush_idex=1, flush_exmem=0, pc_write=1. Counter decrements each cycle; exit to RUN at 0.
  - A new taken branch reloads the counter.
- Reset asserted mid-stall or mid-flush: the next edge returns to RUN with counters zeroed; no residual bubbles.
- Counter widths: 3 bits stall, 2 bits flush; parameters outside their range are an elaboration error.

Optional Feature:
HAZARD_STATS_EN:
- Defined: adds outputs stall_count[CNT_W-1:0] and flush_count[CNT_W-1:0].
  - stall_count increments each cycle idex_bubble=1; flush_count increments each cycle flush_ifid=1.
  - Both saturate at all-ones and clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package pipeline_pkg: state encoding constants (RUN/LSTALL/FLUSH/MWAIT), XZR_IDX=31, REG_IDX_W=5.
- One sub-module, load_use_detect: purely combinational hazard equation, reused later by the forwarding unit.

Test Plan:
- LDUR X2 in EX (ex_mem_read=1, ex_rd=2), ADD in ID with id_rn=2 -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1, then RUN; with LOAD_STALL_CYCLES=3, exactly 3 bubble cycles.
- ex_rd=31, id_rn=31, load in EX -> no stall; id_uses_rm=0 with id_rm==ex_rd -> no stall.
- Hazard and mem_branch_taken in the same cycle -> all three flushes asserted, idex_bubble=0, state=RUN next (FLUSH_CYCLES=1).
- mem_ready=0 for 4 cycles during LSTALL with 2 stall cycles remaining -> hold_all=1 for 4 cycles, then 2 more bubble cycles, then RUN.
- reset=1 for one cycle mid-FLUSH (FLUSH_CYCLES=3) -> next cycle state=0, all flush_*=0, pc_write=1.
- HAZARD_STATS_EN with CNT_W=2: 5 stall cycles -> stall_count saturates at 3.

Source files
------------

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline constants and hazard controller state encoding
package pipeline_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] XZR_IDX = 5'd31;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        FLUSH  = 2'd2,
        MWAIT  = 2'd3
    } hazard_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - decode-stage hazard controller signal bundle; HAZARD_STATS_EN adds counters
interface pipeline_hazard_ctrl_if
    import pipeline_pkg::*;
`ifdef HAZARD_STATS_EN
    #(parameter int CNT_W = 16)
`endif
    ;

    logic [REG_IDX_W-1:0] id_rn;
    logic [REG_IDX_W-1:0] id_rm;
    logic                 id_uses_rn;
    logic                 id_uses_rm;
    logic                 ex_mem_read;
    logic [REG_IDX_W-1:0] ex_rd;
    logic                 mem_branch_taken;
    logic                 mem_ready;
    logic                 pc_write;
    logic                 ifid_write;
    logic                 idex_bubble;
    logic                 hold_all;
    logic                 flush_ifid;
    logic                 flush_idex;
    logic                 flush_exmem;
    logic [1:0]           state;
`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0]     stall_count;
    logic [CNT_W-1:0]     flush_count;
`endif

    modport master (
        output id_rn, id_rm, id_uses_rn, id_uses_rm, ex_mem_read, ex_rd,
               mem_branch_taken, mem_ready,
        input  pc_write, ifid_write, idex_bubble, hold_all,
               flush_ifid, flush_idex, flush_exmem, state
`ifdef HAZARD_STATS_EN
        , input stall_count, flush_count
`endif
    );

    modport slave (
        input  id_rn, id_rm, id_uses_rn, id_uses_rm, ex_mem_read, ex_rd,
               mem_branch_taken, mem_ready,
        output pc_write, ifid_write, idex_bubble, hold_all,
               flush_ifid, flush_idex, flush_exmem, state
`ifdef HAZARD_STATS_EN
        , output stall_count, flush_count
`endif
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// rtl/pipeline_hazard_ctrl_load_use_detect.sv - combinational load-use hazard equation
module load_use_detect
    import pipeline_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rn,
    input  logic [REG_IDX_W-1:0] id_rm,
    input  logic                 id_uses_rn,
    input  logic                 id_uses_rm,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rd,
    output logic                 hazard
);

    // A load into XZR writes nothing, so it can never feed a dependent reader
    assign hazard = ex_mem_read && (ex_rd != XZR_IDX) &&
                    ((id_uses_rn && (id_rn == ex_rd)) ||
                     (id_uses_rm && (id_rm == ex_rd)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - decode-stage stall/flush/memory-wait sequencer; HAZARD_STATS_EN adds stall/flush counters
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int CNT_W             = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave bus
);

    if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 7 ||
        FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3 || CNT_W < 1) begin : g_param_check
        $error("pipeline_hazard_ctrl: parameter out of range");
    end

    localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

    hazard_state_e state_q, state_d, eff_state;
    logic [2:0]    stall_cnt_q, stall_cnt_d;
    logic [1:0]    flush_cnt_q, flush_cnt_d;
    logic          hazard;

    load_use_detect u_detect (
        .id_rn       (bus.id_rn),
        .id_rm       (bus.id_rm),
        .id_uses_rn  (bus.id_uses_rn),
        .id_uses_rm  (bus.id_uses_rm),
        .ex_mem_read (bus.ex_mem_read),
        .ex_rd       (bus.ex_rd),
        .hazard      (hazard)
    );

    // State and counters; reset drops any pending stall or flush work
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            stall_cnt_q <= 3'd0;
            flush_cnt_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Leaving MWAIT resumes whichever activity still has cycles left on its counter
    always_comb begin
        eff_state = state_q;
        if (state_q == MWAIT) begin
            if (stall_cnt_q != 3'd0)      eff_state = LSTALL;
            else if (flush_cnt_q != 2'd0) eff_state = FLUSH;
            else                          eff_state = RUN;
        end
    end

    // Next state and pipeline controls: memory wait beats branch beats load-use
    always_comb begin
        state_d          = state_q;
        stall_cnt_d      = stall_cnt_q;
        flush_cnt_d      = flush_cnt_q;
        bus.pc_write     = 1'b1;
        bus.ifid_write   = 1'b1;
        bus.idex_bubble  = 1'b0;
        bus.hold_all     = 1'b0;
        bus.flush_ifid   = 1'b0;
        bus.flush_idex   = 1'b0;
        bus.flush_exmem  = 1'b0;
        if (!bus.mem_ready) begin
            bus.pc_write   = 1'b0;
            bus.ifid_write = 1'b0;
            bus.hold_all   = 1'b1;
            state_d        = MWAIT;
        end else if (bus.mem_branch_taken) begin
            bus.flush_ifid  = 1'b1;
            bus.flush_idex  = 1'b1;
            bus.flush_exmem = 1'b1;
            stall_cnt_d     = 3'd0;
            flush_cnt_d     = FLUSH_RELOAD;
            state_d         = (FLUSH_RELOAD != 2'd0) ? FLUSH : RUN;
        end else begin
            case (eff_state)
                LSTALL: begin
                    bus.pc_write    = 1'b0;
                    bus.ifid_write  = 1'b0;
                    bus.idex_bubble = 1'b1;
                    stall_cnt_d     = stall_cnt_q - 3'd1;
                    state_d         = (stall_cnt_q == 3'd1) ? RUN : LSTALL;
                end
                FLUSH: begin
                    bus.flush_ifid = 1'b1;
                    bus.flush_idex = 1'b1;
                    flush_cnt_d    = flush_cnt_q - 2'd1;
                    state_d        = (flush_cnt_q == 2'd1) ? RUN : FLUSH;
                end
                default: begin
                    state_d = RUN;
                    if (hazard) begin
                        bus.pc_write    = 1'b0;
                        bus.ifid_write  = 1'b0;
                        bus.idex_bubble = 1'b1;
                        stall_cnt_d     = STALL_RELOAD;
                        state_d         = (STALL_RELOAD != 3'd0) ? LSTALL : RUN;
                    end
                end
            endcase
        end
    end

    assign bus.state = state_q;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_count_q;
    logic [CNT_W-1:0] flush_count_q;

    // Saturating counts of bubble cycles and front-end flush cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            if (bus.idex_bubble && (stall_count_q != '1))
                stall_count_q <= stall_count_q + 1'b1;
            if (bus.flush_ifid && (flush_count_q != '1))
                flush_count_q <= flush_count_q + 1'b1;
        end
    end

    assign bus.stall_count = stall_count_q;
    assign bus.flush_count = flush_count_q;
`endif

endmodule
